// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the PPU $2006/$2007 data port.
package ppu_pkg;
   typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_CAPT} ppu_port_state_t;
   localparam logic [2:0]  REG_PPUADDR = 3'd6;
   localparam logic [2:0]  REG_PPUDATA = 3'd7;
   localparam logic [13:0] INC_ROW     = 14'd32;
   // Nametable space $2000-$3EFF is served by VRAM; everything else goes to ext.
   function automatic logic is_nt(logic [13:0] a);
      return (a[13:12] == 2'b10) || (a[13:8] >= 6'h30 && a[13:8] <= 6'h3E);
   endfunction
endpackage

// File: rtl/ppu_data_port_if.sv
// ppu_data_port_if: CPU register side and PPU memory bus side of the data port.
interface ppu_data_port_if #(parameter int VRAM_AW = 12);
   logic [2:0]         reg_sel;
   logic               cpu_wr;
   logic               cpu_rd;
   logic [7:0]         cpu_wdata;
   logic               inc32;
   logic               status_rd;
   logic [7:0]         cpu_rdata;
   logic               rd_valid;
   logic               busy;
   logic               overrun;
   logic [VRAM_AW-1:0] vram_addr;
   logic [7:0]         vram_wdata;
   logic               vram_wren;
   logic               vram_rden;
   logic [7:0]         vram_rdata;
   logic [13:0]        ext_addr;
   logic [7:0]         ext_wdata;
   logic               ext_wren;
   logic               ext_rden;
   logic [7:0]         ext_rdata;
   modport slave (
      input  reg_sel, cpu_wr, cpu_rd, cpu_wdata, inc32, status_rd, vram_rdata, ext_rdata,
      output cpu_rdata, rd_valid, busy, overrun, vram_addr, vram_wdata, vram_wren, vram_rden,
             ext_addr, ext_wdata, ext_wren, ext_rden
   );
   modport master (
      output reg_sel, cpu_wr, cpu_rd, cpu_wdata, inc32, status_rd, vram_rdata, ext_rdata,
      input  cpu_rdata, rd_valid, busy, overrun, vram_addr, vram_wdata, vram_wren, vram_rden,
             ext_addr, ext_wdata, ext_wren, ext_rden
   );
endinterface

// File: rtl/ppu_addr_latch.sv
// ppu_addr_latch: $2006 two-write address sequencing, toggle clear and post-access increment of v.
module ppu_addr_latch
   import ppu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        addr_wr_i,
   input  logic [7:0]  wdata_i,
   input  logic        status_rd_i,
   input  logic        inc_en_i,
   input  logic        inc32_i,
   output logic [13:0] v_o
);
   logic [5:0]  t_hi_q, t_hi_d;
   logic        w_q, w_d;
   logic [13:0] v_q, v_d;
   // A $2006 load in the same cycle as an increment wins; the CPU's new address takes effect.
   always_comb begin
      w_d    = status_rd_i ? 1'b0 : (addr_wr_i ? ~w_q : w_q);
      t_hi_d = (addr_wr_i && !w_q) ? wdata_i[5:0] : t_hi_q;
      v_d    = (addr_wr_i && w_q) ? {t_hi_q, wdata_i}
             : inc_en_i ? v_q + (inc32_i ? INC_ROW : 14'd1) : v_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t_hi_q <= '0;
         w_q    <= 1'b0;
         v_q    <= '0;
      end else begin
         t_hi_q <= t_hi_d;
         w_q    <= w_d;
         v_q    <= v_d;
      end
   end
   assign v_o = v_q;
endmodule

// File: rtl/ppu_data_port.sv
// ppu_data_port: CPU-side PPUADDR/PPUDATA initiator; single-cycle write strobes and
// one-read-behind buffered reads, routed to VRAM (nametables) or the ext port.
module ppu_data_port
   import ppu_pkg::*;
#(
   parameter int VRAM_AW = 12
) (
   input logic            clk,
   input logic            reset_n,
   ppu_data_port_if.slave bus
);
   ppu_port_state_t state_q;
   logic [13:0] v, addr_q;
   logic [7:0]  wdata_q, rbuf_q, cpu_rdata_q;
   logic        nt_q, rd_valid_q, overrun_q;
   logic        vram_wren_q, ext_wren_q, vram_rden_q, ext_rden_q;
   logic        busy, wr_data, rd_data, rd_other, addr_wr, inc_en;
   // Write beats read when both strobes arrive together.
   assign busy     = state_q != IDLE;
   assign addr_wr  = bus.cpu_wr && bus.reg_sel == REG_PPUADDR;
   assign wr_data  = bus.cpu_wr && bus.reg_sel == REG_PPUDATA;
   assign rd_data  = bus.cpu_rd && !bus.cpu_wr && bus.reg_sel == REG_PPUDATA;
   assign rd_other = bus.cpu_rd && !bus.cpu_wr && bus.reg_sel != REG_PPUDATA;
   assign inc_en   = state_q == WR_ISSUE || state_q == RD_CAPT;
   ppu_addr_latch u_latch (
      .clk        (clk),
      .reset_n    (reset_n),
      .addr_wr_i  (addr_wr),
      .wdata_i    (bus.cpu_wdata),
      .status_rd_i(bus.status_rd),
      .inc_en_i   (inc_en),
      .inc32_i    (bus.inc32),
      .v_o        (v)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         rbuf_q      <= '0;
         cpu_rdata_q <= '0;
         nt_q        <= 1'b0;
         rd_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         vram_wren_q <= 1'b0;
         ext_wren_q  <= 1'b0;
         vram_rden_q <= 1'b0;
         ext_rden_q  <= 1'b0;
      end else begin
         rd_valid_q  <= 1'b0;
         vram_wren_q <= 1'b0;
         ext_wren_q  <= 1'b0;
         vram_rden_q <= 1'b0;
         ext_rden_q  <= 1'b0;
         if (busy && (wr_data || rd_data)) overrun_q <= 1'b1;
         if (rd_other) begin
            cpu_rdata_q <= 8'h00;
            rd_valid_q  <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (wr_data) begin
                  state_q     <= WR_ISSUE;
                  addr_q      <= v;
                  wdata_q     <= bus.cpu_wdata;
                  nt_q        <= is_nt(v);
                  vram_wren_q <= is_nt(v);
                  ext_wren_q  <= !is_nt(v);
               end else if (rd_data) begin
                  state_q     <= RD_ISSUE;
                  addr_q      <= v;
                  nt_q        <= is_nt(v);
                  vram_rden_q <= is_nt(v);
                  ext_rden_q  <= !is_nt(v);
                  cpu_rdata_q <= rbuf_q;
                  rd_valid_q  <= 1'b1;
               end
            end
            WR_ISSUE: state_q <= IDLE;
            RD_ISSUE: state_q <= RD_CAPT;
            RD_CAPT: begin
               rbuf_q  <= nt_q ? bus.vram_rdata : bus.ext_rdata;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.busy       = busy;
   assign bus.overrun    = overrun_q;
   assign bus.vram_addr  = addr_q[VRAM_AW-1:0];
   assign bus.vram_wdata = wdata_q;
   assign bus.vram_wren  = vram_wren_q;
   assign bus.vram_rden  = vram_rden_q;
   assign bus.ext_addr   = addr_q;
   assign bus.ext_wdata  = wdata_q;
   assign bus.ext_wren   = ext_wren_q;
   assign bus.ext_rden   = ext_rden_q;
endmodule

// File: tb/tb_ppu_data_port.sv
// tb_ppu_data_port: scoreboard bench; expected CPU returns and bus strobes are queued at stimulus time.
module tb_ppu_data_port;
   localparam int K_CPU = 0, K_VW = 1, K_EW = 2, K_VR = 3, K_ER = 4;
   typedef struct {
      int          kind;
      logic [13:0] addr;
      logic [7:0]  data;
   } ev_t;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   ppu_data_port_if #(.VRAM_AW(12)) bus ();
   ppu_data_port #(.VRAM_AW(12)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   ev_t         q[$];
   ev_t         e;
   int          total = 0, bad = 0, n, ko;
   logic [13:0] mv, ao;
   logic [7:0]  mrbuf = 8'h00;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [7:0] vval(logic [11:0] a);
      return a[7:0] ^ 8'h5A ^ {4'h0, a[11:8]};
   endfunction
   function automatic logic [7:0] xval(logic [13:0] a);
      return a[7:0] ^ 8'hC3 ^ {2'b00, a[13:8]};
   endfunction
   function automatic logic nt_m(logic [13:0] a);
      return a >= 14'h2000 && a <= 14'h3EFF;
   endfunction
   // Memories answer one cycle after the read strobe; idle cycles return junk.
   always @(posedge clk) begin
      bus.vram_rdata <= bus.vram_rden ? vval(bus.vram_addr) : 8'hEE;
      bus.ext_rdata  <= bus.ext_rden ? xval(bus.ext_addr) : 8'hDD;
   end
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.rd_valid) begin
            if (q.size() == 0) chk("extra_rd", 1, 0);
            else begin
               e = q.pop_front();
               chk("rd_kind", ko, e.kind == K_CPU ? ko : K_CPU);
               chk("rd_is_cpu", e.kind, K_CPU);
               chk("rd_data", bus.cpu_rdata, e.data);
            end
         end
         n = int'(bus.vram_wren) + int'(bus.ext_wren) + int'(bus.vram_rden) + int'(bus.ext_rden);
         if (n != 0) begin
            chk("excl", n, 1);
            ko = bus.vram_wren ? K_VW : bus.ext_wren ? K_EW : bus.vram_rden ? K_VR : K_ER;
            ao = (bus.vram_wren || bus.vram_rden) ? {2'b00, bus.vram_addr} : bus.ext_addr;
            if (q.size() == 0) chk("extra_strobe", 1, 0);
            else begin
               e = q.pop_front();
               chk("kind", ko, e.kind);
               chk("addr", ao, e.addr);
               if (ko == K_VW) chk("vwdata", bus.vram_wdata, e.data);
               if (ko == K_EW) chk("xwdata", bus.ext_wdata, e.data);
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle(int c);
      repeat (c) tick();
   endtask
   task automatic wr(logic [2:0] r, logic [7:0] d);
      bus.reg_sel = r; bus.cpu_wdata = d; bus.cpu_wr = 1'b1;
      tick();
      bus.cpu_wr = 1'b0;
   endtask
   task automatic rd(logic [2:0] r);
      bus.reg_sel = r; bus.cpu_rd = 1'b1;
      tick();
      bus.cpu_rd = 1'b0;
   endtask
   task automatic setv(logic [13:0] a);
      wr(3'd6, {2'b00, a[13:8]});
      wr(3'd6, a[7:0]);
      mv = a;
   endtask
   task automatic push_acc(int kv, int kx);
      q.push_back('{nt_m(mv) ? kv : kx, nt_m(mv) ? {2'b00, mv[11:0]} : mv, 8'h00});
   endtask
   task automatic pw(logic [7:0] d);
      q.push_back('{nt_m(mv) ? K_VW : K_EW, nt_m(mv) ? {2'b00, mv[11:0]} : mv, d});
      wr(3'd7, d);
      mv = mv + (bus.inc32 ? 14'd32 : 14'd1);
      idle(2);
   endtask
   task automatic pr();
      q.push_back('{K_CPU, 14'h0, mrbuf});
      push_acc(K_VR, K_ER);
      mrbuf = nt_m(mv) ? vval(mv[11:0]) : xval(mv);
      rd(3'd7);
      mv = mv + (bus.inc32 ? 14'd32 : 14'd1);
      idle(3);
   endtask
   task automatic chk_reset_outs(string tag);
      chk({tag, "_rdata"}, bus.cpu_rdata, 0);
      chk({tag, "_rvalid"}, bus.rd_valid, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_ovr"}, bus.overrun, 0);
      chk({tag, "_strobes"}, {bus.vram_wren, bus.vram_rden, bus.ext_wren, bus.ext_rden}, 0);
      chk({tag, "_vaddr"}, bus.vram_addr, 0);
      chk({tag, "_xaddr"}, bus.ext_addr, 0);
   endtask
   initial begin
      bus.reg_sel = 3'd0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_wdata = 8'h00;
      bus.inc32 = 1'b0; bus.status_rd = 1'b0;
      #12;
      chk_reset_outs("rst");
      tick();
      reset_n = 1'b1;
      idle(2);
      // basic write, then a second write proves the +1 step
      wr(3'd6, 8'h21); wr(3'd6, 8'h08); mv = 14'h2108;
      pw(8'hAB); pw(8'hCD);
      // buffered reads: first returns old buffer
      setv(14'h2000); pr(); pr();
      // +32 stepping, then wrap at the top of the 14-bit space
      bus.inc32 = 1'b1; setv(14'h23E0); pw(8'h11); pw(8'h22);
      bus.inc32 = 1'b0; setv(14'h3FFF); pw(8'h33); pw(8'h44);
      // status read clears the write toggle
      wr(3'd6, 8'h3F);
      bus.status_rd = 1'b1; tick(); bus.status_rd = 1'b0;
      wr(3'd6, 8'h21); wr(3'd6, 8'h00); mv = 14'h2100; pw(8'h55);
      // status read together with the first $2006 write: write lands, toggle ends cleared
      bus.status_rd = 1'b1; wr(3'd6, 8'h3F); bus.status_rd = 1'b0;
      wr(3'd6, 8'h27); wr(3'd6, 8'h10); mv = 14'h2710; pw(8'h66);
      // target decode at the palette and nametable edges
      setv(14'h3F00); pw(8'h0F); setv(14'h3000); pw(8'h77); setv(14'h3EFF); pw(8'h88);
      setv(14'h0010); pr(); pr();
      // non-$2007 reads return zero
      q.push_back('{K_CPU, 14'h0, 8'h00}); rd(3'd2); idle(1);
      q.push_back('{K_CPU, 14'h0, 8'h00}); rd(3'd6); idle(1);
      // read and write together: write only
      setv(14'h2300);
      q.push_back('{K_VW, 14'h300, 8'h99});
      bus.reg_sel = 3'd7; bus.cpu_wdata = 8'h99; bus.cpu_wr = 1'b1; bus.cpu_rd = 1'b1;
      tick();
      bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; mv = mv + 14'd1;
      idle(2);
      // access while busy is dropped and flagged
      chk("ovr_clear", bus.overrun, 0);
      setv(14'h2200);
      q.push_back('{K_CPU, 14'h0, mrbuf});
      q.push_back('{K_VR, 14'h200, 8'h00});
      mrbuf = vval(12'h200);
      rd(3'd7);
      chk("busy_rd", bus.busy, 1);
      wr(3'd7, 8'h5C);
      mv = mv + 14'd1;
      idle(3);
      chk("ovr_set", bus.overrun, 1);
      chk("idle_busy", bus.busy, 0);
      pw(8'h6A);
      // reset in the middle of a read access
      setv(14'h2400);
      rd(3'd7);
      reset_n = 1'b0;
      #1;
      chk_reset_outs("midrst");
      tick();
      reset_n = 1'b1;
      mrbuf = 8'h00;
      idle(1);
      setv(14'h2000); pr(); pr();
      idle(4);
      chk("pending", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
